led_matrix_pwm_scan: RTL and testbench

LED_MATRIX_PWM_SCAN -- requirements
Module: led_matrix_pwm_scan

---
 rtl/led_matrix_pwm_scan.sv | 196 +++++++++++++++++++
 tb/tb_led_matrix_pwm_scan.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_pwm_scan.sv
// Row-scanned LED matrix driver: double-buffered pixel levels, per-row blanking and PWM.
// Optional LED_GAMMA_EN: squares the stored level ((level*level) >> BW) before PWM compare.
module led_matrix_pwm_scan #(
    parameter  int ROWS        = 8,
    parameter  int COLS        = 8,
    parameter  int BW          = 6,
    parameter  int CLK_DIV     = 100,
    parameter  int BLANK_TICKS = 2,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW          = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_row,
    input  logic [CW-1:0]   wr_col,
    input  logic [BW-1:0]   wr_data,
    input  logic            swap_req,
    output logic            swap_ack,
    output logic            frame_start,
    output logic [ROWS-1:0] row_pins,
    output logic [COLS-1:0] col_pins
);

    localparam int DW  = $clog2(CLK_DIV);
    localparam int BCW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    localparam logic [DW-1:0]  DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_TICKS - 1);
    localparam logic [BW-1:0]  PWM_LAST   = {BW{1'b1}};
    localparam logic [RW-1:0]  ROW_LAST   = RW'(ROWS - 1);
    localparam logic [RW:0]    ROWS_L     = (RW + 1)'(ROWS);
    localparam logic [CW:0]    COLS_L     = (CW + 1)'(COLS);

    typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [DW-1:0]   div_r;
    logic            tick_s;
    logic [BW-1:0]   pwm_r, pwm_s;
    logic [BCW-1:0]  blank_r, blank_s;
    logic [RW-1:0]   row_r, row_s;
    logic            frame_end_s;
    logic            swap_go_s;
    logic            wr_ok_s;
    logic            front_r;
    logic            pend_r;
    logic [BW-1:0]   mem_r [2][ROWS][COLS];
    logic [ROWS-1:0] row_pins_s;
    logic [COLS-1:0] col_pins_s;
    logic            frame_start_s;

    // Brightness transfer applied just before the PWM compare.
    function automatic logic [BW-1:0] level_f(input logic [BW-1:0] lv);
`ifdef LED_GAMMA_EN
        logic [2*BW-1:0] prod;
        prod = {{BW{1'b0}}, lv} * {{BW{1'b0}}, lv};
        return prod[2*BW-1:BW];
`else
        return lv;
`endif
    endfunction

    assign tick_s    = (div_r == DIV_LAST);
    assign swap_go_s = frame_end_s & (pend_r | swap_req);
    assign wr_ok_s   = wr_en && ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);

    // PWM tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= '0;
        end else if (tick_s) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // Scan FSM and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BLANK;
            pwm_r   <= '0;
            blank_r <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_s;
            pwm_r   <= pwm_s;
            blank_r <= blank_s;
            row_r   <= row_s;
        end
    end

    // Scan FSM next state; everything advances only on a tick.
    always_comb begin
        state_s     = state_r;
        pwm_s       = pwm_r;
        blank_s     = blank_r;
        row_s       = row_r;
        frame_end_s = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_BLANK: begin
                    if (blank_r == BLANK_LAST) begin
                        state_s = ST_DRIVE;
                        blank_s = '0;
                        pwm_s   = '0;
                    end else begin
                        blank_s = blank_r + BCW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (pwm_r == PWM_LAST) begin
                        state_s     = ST_BLANK;
                        pwm_s       = '0;
                        blank_s     = '0;
                        frame_end_s = (row_r == ROW_LAST);
                        row_s       = (row_r == ROW_LAST) ? '0 : row_r + RW'(1);
                    end else begin
                        pwm_s = pwm_r + BW'(1);
                    end
                end
                default: begin
                    state_s = ST_BLANK;
                    pwm_s   = '0;
                    blank_s = '0;
                    row_s   = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Front-buffer select and sticky swap request; a request landing on the frame end is honoured there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_r <= 1'b0;
            pend_r  <= 1'b0;
        end else if (swap_go_s) begin
            front_r <= ~front_r;
            pend_r  <= 1'b0;
        end else if (swap_req) begin
            pend_r  <= 1'b1;
        end else begin
            pend_r  <= pend_r;
        end
    end

    // Pixel storage; writes always go to the buffer that is back before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        mem_r[b][r][c] <= '0;
                    end
                end
            end
        end else if (wr_ok_s) begin
            mem_r[~front_r][wr_row][wr_col] <= wr_data;
        end
    end

    // Pin patterns decoded from the current scan state.
    always_comb begin
        row_pins_s    = {ROWS{1'b1}};
        col_pins_s    = '0;
        frame_start_s = (state_r == ST_BLANK) && (row_r == '0) && (blank_r == '0) && (div_r == '0);
        if (state_r == ST_DRIVE) begin
            row_pins_s = ~(ROWS'(1) << (ROW_LAST - row_r));
            for (int c = 0; c < COLS; c++) begin
                col_pins_s[c] = (level_f(mem_r[front_r][row_r][c]) > pwm_r);
            end
        end else begin
            row_pins_s = {ROWS{1'b1}};
            col_pins_s = '0;
        end
    end

    // Output registers: pins lag the scan state by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_pins    <= {ROWS{1'b1}};
            col_pins    <= '0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            row_pins    <= row_pins_s;
            col_pins    <= col_pins_s;
            swap_ack    <= swap_go_s;
            frame_start <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_led_matrix_pwm_scan.sv
// Bench for led_matrix_pwm_scan: frame-position reference model checked every cycle, plus duty tables.
module tb_led_matrix_pwm_scan;

    localparam int ROWS        = 8;
    localparam int COLS        = 8;
    localparam int BW          = 6;
    localparam int CLK_DIV     = 4;
    localparam int BLANK_TICKS = 2;
    localparam int ROW_TICKS   = BLANK_TICKS + (1 << BW);
    localparam int FRAME_CYC   = ROWS * ROW_TICKS * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_row = 3'd0;
    logic [2:0] wr_col = 3'd0;
    logic [5:0] wr_data = 6'd0;
    logic       swap_req = 1'b0;
    logic       swap_ack;
    logic       frame_start;
    logic [7:0] row_pins;
    logic [7:0] col_pins;

    led_matrix_pwm_scan #(
        .ROWS(ROWS), .COLS(COLS), .BW(BW), .CLK_DIV(CLK_DIV), .BLANK_TICKS(BLANK_TICKS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
        .frame_start(frame_start), .row_pins(row_pins), .col_pins(col_pins)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        int lvl;
        int ticks;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   n = 0;
    int   mbuf [2][ROWS][COLS];
    int   mfront = 0;
    bit   mpend = 1'b0;
    int   ack_cnt = 0;
    int   fs_cnt = 0;
    int   hi_cnt [ROWS][COLS];
    int   blank_lit = 0;
    vec_t tbl [5];

    function automatic int eff(input int lv);
`ifdef LED_GAMMA_EN
        return (lv * lv) >> BW;
`else
        return lv;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, n);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mbuf[b][r][c] = 0;
        mfront = 0;
        mpend  = 1'b0;
        n      = 0;
    endtask

    // One clock: capture inputs, advance, then compare against the frame-position model.
    task automatic step();
        logic       w, sr, ea, efs, fe;
        int         wr, wc, wd, m, t, p, row, q, pwm;
        logic [7:0] er, ec;
        w = wr_en; wr = int'(wr_row); wc = int'(wr_col); wd = int'(wr_data); sr = swap_req;
        @(posedge clk);
        #1;
        n++;
        m   = n - 1;
        t   = m / CLK_DIV;
        p   = t % (ROWS * ROW_TICKS);
        row = p / ROW_TICKS;
        q   = p % ROW_TICKS;
        er  = 8'hFF;
        ec  = 8'h00;
        if (q >= BLANK_TICKS) begin
            pwm = q - BLANK_TICKS;
            er  = ~(8'h01 << (ROWS - 1 - row));
            for (int c = 0; c < COLS; c++) ec[c] = (eff(mbuf[mfront][row][c]) > pwm);
        end
        efs = ((m % FRAME_CYC) == 0);
        fe  = ((n % FRAME_CYC) == 0);
        if (w) mbuf[1 - mfront][wr][wc] = wd;
        ea = 1'b0;
        if (fe && (mpend || sr)) begin
            mfront = 1 - mfront;
            mpend  = 1'b0;
            ea     = 1'b1;
        end else if (sr) begin
            mpend = 1'b1;
        end
        check("row_pins", {24'd0, row_pins}, {24'd0, er});
        check("col_pins", {24'd0, col_pins}, {24'd0, ec});
        check("swap_ack", {31'd0, swap_ack}, {31'd0, ea});
        check("frame_start", {31'd0, frame_start}, {31'd0, efs});
        if (swap_ack === 1'b1) ack_cnt++;
        if (frame_start === 1'b1) fs_cnt++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row_pins", {24'd0, row_pins}, 32'hFF);
        check("rst_col_pins", {24'd0, col_pins}, 32'h0);
        check("rst_swap_ack", {31'd0, swap_ack}, 32'h0);
        check("rst_frame_start", {31'd0, frame_start}, 32'h0);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic write_px(input int r, input int c, input int d);
        wr_en = 1'b1; wr_row = 3'(r); wr_col = 3'(c); wr_data = 6'(d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 2 * FRAME_CYC && !got; k++) begin
            step();
            if (swap_ack === 1'b1) got = 1'b1;
        end
        check(name, {31'd0, got}, 32'h1);
    endtask

    // Runs one full frame counting lit cycles per pixel and any column lit while blank.
    task automatic measure_frame();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                hi_cnt[r][c] = 0;
        blank_lit = 0;
        repeat (FRAME_CYC) begin
            step();
            if (row_pins === 8'hFF && col_pins !== 8'h00) blank_lit++;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (row_pins[ROWS-1-r] === 1'b0 && col_pins[c] === 1'b1) hi_cnt[r][c]++;
        end
    endtask

    initial begin
`ifdef LED_GAMMA_EN
        tbl[0] = '{2, 5, 32, 16};
        tbl[1] = '{3, 1, 63, 62};
        tbl[2] = '{3, 2, 0, 0};
        tbl[3] = '{0, 0, 1, 0};
        tbl[4] = '{7, 7, 17, 4};
`else
        tbl[0] = '{2, 5, 32, 32};
        tbl[1] = '{3, 1, 63, 63};
        tbl[2] = '{3, 2, 0, 0};
        tbl[3] = '{0, 0, 1, 1};
        tbl[4] = '{7, 7, 17, 17};
`endif
        do_reset();

        // Idle scan: blank display, frame_start spaced one frame apart.
        fs_cnt = 0; ack_cnt = 0;
        repeat (2 * FRAME_CYC + 10) step();
        check("idle_frame_starts", fs_cnt, 3);
        check("idle_acks", ack_cnt, 0);

        // Duty table.
        for (int i = 0; i < 5; i++) write_px(tbl[i].r, tbl[i].c, tbl[i].lvl);
        pulse_swap();
        wait_ack("table_ack_wait");
        measure_frame();
        for (int i = 0; i < 5; i++)
            check($sformatf("duty_r%0d_c%0d", tbl[i].r, tbl[i].c),
                  hi_cnt[tbl[i].r][tbl[i].c], tbl[i].ticks * CLK_DIV);
        check("blank_lit", blank_lit, 0);

        // Three requests inside one frame yield a single ack.
        ack_cnt = 0;
        repeat (3) begin
            pulse_swap();
            repeat (100) step();
        end
        for (int k = 0; k < 2 * FRAME_CYC && (n % FRAME_CYC) != 0; k++) step();
        repeat (FRAME_CYC) step();
        check("triple_req_acks", ack_cnt, 1);

        // Request and write landing exactly on the frame-end edge.
        for (int k = 0; k < 2 * FRAME_CYC && (n % FRAME_CYC) != FRAME_CYC - 1; k++) step();
        wr_en = 1'b1; wr_row = 3'd4; wr_col = 3'd3; wr_data = 6'd45;
        swap_req = 1'b1;
        step();
        wr_en = 1'b0; swap_req = 1'b0;
        check("ack_same_frame_end", {31'd0, swap_ack}, 32'h1);
        measure_frame();
        check("coincident_write_duty", hi_cnt[4][3], eff(45) * CLK_DIV);
        check("blank_lit_2", blank_lit, 0);

        // Randomised writes and swap requests.
        repeat (3 * FRAME_CYC) begin
            wr_en    = ($urandom_range(3, 0) == 0);
            wr_row   = 3'($urandom_range(7, 0));
            wr_col   = 3'($urandom_range(7, 0));
            wr_data  = 6'($urandom_range(63, 0));
            swap_req = ($urandom_range(499, 0) == 0);
            step();
        end
        wr_en = 1'b0; swap_req = 1'b0;

        // Reset in the middle of a DRIVE phase.
        for (int k = 0; k < FRAME_CYC && ((n / CLK_DIV) % ROW_TICKS) < BLANK_TICKS + 5; k++) step();
        rst_n = 1'b0;
        #1;
        check("midreset_row_pins", {24'd0, row_pins}, 32'hFF);
        check("midreset_col_pins", {24'd0, col_pins}, 32'h0);
        do_reset();
        pulse_swap();
        wait_ack("post_reset_ack_wait");
        measure_frame();
        begin
            int lit;
            lit = 0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    lit += hi_cnt[r][c];
            check("post_reset_cleared", lit, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
